// File: rtl/dic_time_datapath_pkg.sv
// Shared definitions for the desk-clock time datapath and the display stage:
// digit width, digit limits and the packed MM:SS time type.
package dic_time_datapath_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DEF_MAX_MTENS = 4'd5;
    localparam logic [DIGIT_W-1:0] DEF_MAX_STENS = 4'd5;
    localparam logic [DIGIT_W-1:0] DEF_MAX_ONES  = 4'd9;

    typedef struct packed {
        logic [DIGIT_W-1:0] mtens;
        logic [DIGIT_W-1:0] mones;
        logic [DIGIT_W-1:0] stens;
        logic [DIGIT_W-1:0] sones;
    } mmss_t;

endpackage

// File: rtl/dic_time_datapath_bcd_digit_cnt.sv
// One BCD digit of the running time: range-checked load, wrap-around
// increment and a carry that ripples combinationally to the next digit.
module bcd_digit_cnt
    import dic_time_datapath_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX_VAL = DEF_MAX_ONES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_i,
    input  logic [DIGIT_W-1:0] ld_val_i,
    input  logic               inc_en_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic [DIGIT_W-1:0] digit_nxt_o,
    output logic               carry_o
);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        // NOTE: default first so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (ld_i) begin
            if (ld_val_i <= MAX_VAL) digit_d = ld_val_i;
        end else if (inc_en_i) begin
            digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst) digit_q <= '0;
        else      digit_q <= digit_d;
    end

    assign digit_o     = digit_q;
    assign digit_nxt_o = digit_d;
    assign carry_o     = inc_en_i && (digit_q == MAX_VAL);

endmodule

// File: rtl/dic_time_datapath.sv
// Desk-clock datapath: running MM:SS time, MM:SS alarm set-point and the
// alarm_ring flag, driven by the control FSM strobes and the decoded digit.
module dic_time_datapath
    import dic_time_datapath_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX_MTENS = DEF_MAX_MTENS,
    parameter logic [DIGIT_W-1:0] MAX_STENS = DEF_MAX_STENS,
    parameter logic [DIGIT_W-1:0] MAX_ONES  = DEF_MAX_ONES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               dicRun,
    input  logic               dicLdMtens,
    input  logic               dicLdMones,
    input  logic               dicLdStens,
    input  logic               dicLdSones,
    input  logic               alarmLdMtens,
    input  logic               alarmLdMones,
    input  logic               alarmLdStens,
    input  logic               alarmLdSones,
    input  logic               alarm_en,
    input  logic [DIGIT_W-1:0] ld_digit,
    output logic [DIGIT_W-1:0] dicMtens,
    output logic [DIGIT_W-1:0] dicMones,
    output logic [DIGIT_W-1:0] dicStens,
    output logic [DIGIT_W-1:0] dicSones,
    output logic [DIGIT_W-1:0] alarmMtens,
    output logic [DIGIT_W-1:0] alarmMones,
    output logic [DIGIT_W-1:0] alarmStens,
    output logic [DIGIT_W-1:0] alarmSones,
    output logic               alarm_ring
);

    mmss_t time_q, time_nxt, alarm_q, alarm_d;
    logic  ring_q, ring_d;
    logic  inc, c_sones, c_stens, c_mones, carry_mtens_unused;

    // A tick that lands on any time-digit load is dropped, not deferred.
    assign inc = dicRun && tick_1hz &&
                 !(dicLdMtens || dicLdMones || dicLdStens || dicLdSones);

    bcd_digit_cnt #(.MAX_VAL(MAX_ONES)) u_sones (
        .clk(clk), .rst(rst), .ld_i(dicLdSones), .ld_val_i(ld_digit), .inc_en_i(inc),
        .digit_o(time_q.sones), .digit_nxt_o(time_nxt.sones), .carry_o(c_sones));

    bcd_digit_cnt #(.MAX_VAL(MAX_STENS)) u_stens (
        .clk(clk), .rst(rst), .ld_i(dicLdStens), .ld_val_i(ld_digit), .inc_en_i(c_sones),
        .digit_o(time_q.stens), .digit_nxt_o(time_nxt.stens), .carry_o(c_stens));

    bcd_digit_cnt #(.MAX_VAL(MAX_ONES)) u_mones (
        .clk(clk), .rst(rst), .ld_i(dicLdMones), .ld_val_i(ld_digit), .inc_en_i(c_stens),
        .digit_o(time_q.mones), .digit_nxt_o(time_nxt.mones), .carry_o(c_mones));

    bcd_digit_cnt #(.MAX_VAL(MAX_MTENS)) u_mtens (
        .clk(clk), .rst(rst), .ld_i(dicLdMtens), .ld_val_i(ld_digit), .inc_en_i(c_mones),
        .digit_o(time_q.mtens), .digit_nxt_o(time_nxt.mtens), .carry_o(carry_mtens_unused));

    always_comb begin
        alarm_d = alarm_q;
        if (alarmLdMtens && ld_digit <= MAX_MTENS) alarm_d.mtens = ld_digit;
        if (alarmLdMones && ld_digit <= MAX_ONES)  alarm_d.mones = ld_digit;
        if (alarmLdStens && ld_digit <= MAX_STENS) alarm_d.stens = ld_digit;
        if (alarmLdSones && ld_digit <= MAX_ONES)  alarm_d.sones = ld_digit;
    end

    // Only an increment can arm the ring; disarming always wins over a match.
    always_comb begin
        ring_d = ring_q;
        if (!alarm_en)                          ring_d = 1'b0;
        else if (inc && (time_nxt == alarm_d))  ring_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alarm_q <= '0;
            ring_q  <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
            ring_q  <= ring_d;
        end
    end

    assign dicMtens   = time_q.mtens;
    assign dicMones   = time_q.mones;
    assign dicStens   = time_q.stens;
    assign dicSones   = time_q.sones;
    assign alarmMtens = alarm_q.mtens;
    assign alarmMones = alarm_q.mones;
    assign alarmStens = alarm_q.stens;
    assign alarmSones = alarm_q.sones;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_dic_time_datapath.sv
// Self-checking bench for dic_time_datapath: directed steps followed by
// random cycles, compared against a seconds-based reference model.
module tb_dic_time_datapath;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, dicRun, alarm_en;
    logic       dicLdMtens, dicLdMones, dicLdStens, dicLdSones;
    logic       alarmLdMtens, alarmLdMones, alarmLdStens, alarmLdSones;
    logic [3:0] ld_digit;
    logic [3:0] dicMtens, dicMones, dicStens, dicSones;
    logic [3:0] alarmMtens, alarmMones, alarmStens, alarmSones;
    logic       alarm_ring;

    int vectors = 0;
    int miscompares = 0;

    // Model state: index 3=Mtens 2=Mones 1=Stens 0=Sones
    int m_t[4];
    int m_a[4];
    bit m_ring;

    always #5 clk = ~clk;

    dic_time_datapath dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .dicRun(dicRun),
        .dicLdMtens(dicLdMtens), .dicLdMones(dicLdMones),
        .dicLdStens(dicLdStens), .dicLdSones(dicLdSones),
        .alarmLdMtens(alarmLdMtens), .alarmLdMones(alarmLdMones),
        .alarmLdStens(alarmLdStens), .alarmLdSones(alarmLdSones),
        .alarm_en(alarm_en), .ld_digit(ld_digit),
        .dicMtens(dicMtens), .dicMones(dicMones), .dicStens(dicStens), .dicSones(dicSones),
        .alarmMtens(alarmMtens), .alarmMones(alarmMones),
        .alarmStens(alarmStens), .alarmSones(alarmSones),
        .alarm_ring(alarm_ring));

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit run, input bit tk, input bit [3:0] dl,
                              input bit [3:0] al, input bit en, input int d);
        bit inc;
        bit eq;
        int secs;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_t[i] = 0;
                m_a[i] = 0;
            end
            m_ring = 1'b0;
            return;
        end
        inc = run && tk && (dl == 4'b0000);
        for (int i = 0; i < 4; i++) begin
            int lim;
            lim = (i % 2 == 1) ? 5 : 9;
            if (dl[i] && d <= lim) m_t[i] = d;
            if (al[i] && d <= lim) m_a[i] = d;
        end
        if (inc) begin
            secs = (m_t[3] * 600 + m_t[2] * 60 + m_t[1] * 10 + m_t[0] + 1) % 3600;
            m_t[3] = secs / 600;
            m_t[2] = (secs / 60) % 10;
            m_t[1] = (secs % 60) / 10;
            m_t[0] = secs % 10;
        end
        eq = 1'b1;
        for (int i = 0; i < 4; i++) if (m_t[i] != m_a[i]) eq = 1'b0;
        if (!en)             m_ring = 1'b0;
        else if (inc && eq)  m_ring = 1'b1;
    endtask

    task automatic drive(input string tag, input bit r, input bit run, input bit tk,
                         input bit [3:0] dl, input bit [3:0] al, input bit en, input int d);
        logic [36:0] exp;
        @(negedge clk);
        rst          = r;
        dicRun       = run;
        tick_1hz     = tk;
        dicLdMtens   = dl[3];
        dicLdMones   = dl[2];
        dicLdStens   = dl[1];
        dicLdSones   = dl[0];
        alarmLdMtens = al[3];
        alarmLdMones = al[2];
        alarmLdStens = al[1];
        alarmLdSones = al[0];
        alarm_en     = en;
        ld_digit     = 4'(d);
        model_step(r, run, tk, dl, al, en, d);
        exp = {4'(m_t[3]), 4'(m_t[2]), 4'(m_t[1]), 4'(m_t[0]),
               4'(m_a[3]), 4'(m_a[2]), 4'(m_a[1]), 4'(m_a[0]), m_ring};
        @(posedge clk);
        #1;
        check(tag, {dicMtens, dicMones, dicStens, dicSones,
                    alarmMtens, alarmMones, alarmStens, alarmSones, alarm_ring}, exp);
    endtask

    initial begin
        rst = 1'b0; tick_1hz = 1'b0; dicRun = 1'b0; alarm_en = 1'b0; ld_digit = '0;
        {dicLdMtens, dicLdMones, dicLdStens, dicLdSones} = '0;
        {alarmLdMtens, alarmLdMones, alarmLdStens, alarmLdSones} = '0;
        for (int i = 0; i < 4; i++) begin
            m_t[i] = 0;
            m_a[i] = 0;
        end
        m_ring = 1'b0;

        drive("reset", 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) drive("frozen", 1, 0, 1, 4'b0000, 4'b0000, 0, 0);

        drive("ld_mtens5", 1, 1, 0, 4'b1000, 4'b0000, 0, 5);
        drive("ld_mones9", 1, 1, 0, 4'b0100, 4'b0000, 0, 9);
        drive("ld_stens5", 1, 1, 0, 4'b0010, 4'b0000, 0, 5);
        drive("ld_sones8", 1, 1, 0, 4'b0001, 4'b0000, 0, 8);
        drive("tick_5959", 1, 1, 1, 4'b0000, 4'b0000, 0, 0);
        drive("wrap_0000", 1, 1, 1, 4'b0000, 4'b0000, 0, 0);

        drive("ld_mtens7", 1, 1, 0, 4'b1000, 4'b0000, 0, 7);
        drive("ld_sones9", 1, 1, 0, 4'b0001, 4'b0000, 0, 9);
        drive("tick_vs_ld", 1, 1, 1, 4'b0010, 4'b0000, 0, 3);
        drive("ld_stens_bad", 1, 1, 0, 4'b0010, 4'b0000, 0, 6);

        drive("al_sones5", 1, 1, 0, 4'b0000, 4'b0001, 1, 5);
        drive("t_stens0", 1, 1, 0, 4'b0010, 4'b0000, 1, 0);
        drive("t_sones3", 1, 1, 0, 4'b0001, 4'b0000, 1, 3);
        drive("tick_0004", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);
        drive("tick_0005", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);
        drive("tick_0006", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);
        drive("tick_0007", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);
        drive("disarm", 1, 1, 0, 4'b0000, 4'b0000, 0, 0);

        drive("al_m1", 1, 1, 0, 4'b0000, 4'b1000, 1, 1);
        drive("al_m2", 1, 1, 0, 4'b0000, 4'b0100, 1, 2);
        drive("al_s3", 1, 1, 0, 4'b0000, 4'b0010, 1, 3);
        drive("al_s4", 1, 1, 0, 4'b0000, 4'b0001, 1, 4);
        drive("t_m1", 1, 1, 0, 4'b1000, 4'b0000, 1, 1);
        drive("t_m2", 1, 1, 0, 4'b0100, 4'b0000, 1, 2);
        drive("t_s3", 1, 1, 0, 4'b0010, 4'b0000, 1, 3);
        drive("t_s4_loadeq", 1, 1, 0, 4'b0001, 4'b0000, 1, 4);
        drive("idle_eq", 1, 1, 0, 4'b0000, 4'b0000, 1, 0);
        drive("t_s3_again", 1, 1, 0, 4'b0001, 4'b0000, 0, 3);
        drive("match_disarmed", 1, 1, 1, 4'b0000, 4'b0000, 0, 0);
        drive("t_s3_arm", 1, 1, 0, 4'b0001, 4'b0000, 1, 3);
        drive("match_armed", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);
        drive("reset_mid", 0, 1, 1, 4'b1111, 4'b1111, 1, 4);
        drive("resume_1", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);
        drive("resume_2", 1, 1, 1, 4'b0000, 4'b0000, 1, 0);

        for (int n = 0; n < 2000; n++) begin
            bit [3:0] dl, al;
            for (int i = 0; i < 4; i++) begin
                dl[i] = ($urandom_range(0, 15) == 0);
                al[i] = ($urandom_range(0, 15) == 0);
            end
            drive("random", $urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 1) == 1, dl, al, $urandom_range(0, 9) != 0,
                  int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dic_time_datapath.md
Name: dic_time_datapath

Overview:
- Datapath stage directly downstream of the desk-clock control FSM.
- Consumes the FSM's run, load-strobe and alarm-enable outputs plus the decoded digit from the UART character decoder.
- Holds the running MM:SS time and the MM:SS alarm set-point as BCD digits, advances time on a 1 Hz strobe, and raises an alarm when the running time reaches the set-point.
- Feeds the digit display/UART echo stage.

Parameters:
MAX_MTENS, 5, highest legal minutes-tens digit
MAX_STENS, 5, highest legal seconds-tens digit
MAX_ONES, 9, highest legal ones digit (minutes and seconds)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
tick_1hz  input  1  one-cycle pulse, once per second
dicRun  input  1  FSM: clock running
dicLdMtens/dicLdMones/dicLdStens/dicLdSones  input  1 each  FSM: load time digit
alarmLdMtens/alarmLdMones/alarmLdStens/alarmLdSones  input  1 each  FSM: load alarm digit
alarm_en  input  1  FSM: alarm armed
ld_digit  input  4  binary value of the decoded ASCII digit (0-9)
dicMtens/dicMones/dicStens/dicSones  output  4 each  running time BCD digits
alarmMtens/alarmMones/alarmStens/alarmSones  output  4 each  alarm set-point BCD digits
alarm_ring  output  1  alarm sounding

Behaviour:
- Reset (rst=0 at a clk edge): all eight digit outputs go to 0 and alarm_ring goes to 0. Reset overrides every other input in the same cycle.
- All outputs are registered. Updates become visible one clk after the qualifying edge.
- Load:
  - A dicLd*/alarmLd* strobe high at an edge writes ld_digit into that digit.
  - Tens digits accept values 0..5 only. Ones digits accept 0..9 only. An out-of-range value leaves the digit unchanged.
  - Multiple strobes in one cycle each load ld_digit.
- Increment:
  - Occurs when dicRun=1, tick_1hz=1 and no dicLd* strobe is high that cycle. A tick coinciding with any dicLd* is discarded, not deferred.
  - Sones 9->0 carries to Stens. Stens 5->0 carries to Mones. Mones 9->0 carries to Mtens. Mtens 5->0 wraps, so 59:59 -> 00:00.
  - Carries resolve in the same cycle; the whole time vector updates at one edge.
  - dicRun=0 freezes the time.
- Alarm digits never change except by alarmLd* or reset.
- Alarm:
  - alarm_ring sets at the edge after an increment produces time == alarm set-point while alarm_en=1.
  - A load that makes them equal does not set it. Only an increment match does.
  - Once set, alarm_ring holds until alarm_en is 0 at an edge, or reset.
  - alarm_en falling and a match in the same cycle: clear wins.
  - alarm_en=0 blocks setting.
- Reset mid-load or mid-ring: reset result only. No residual state.

Decomposition:
- Shared package:
  - BCD digit width (4).
  - Limit constants MAX_MTENS/MAX_STENS/MAX_ONES.
  - A 16-bit MM:SS time struct/typedef used by this block and the display stage.
- One natural sub-module: bcd_digit_cnt.
  - Parameter: max value.
  - Inputs: load, load value, increment-enable.
  - Outputs: digit, carry-out (= enable && digit==max).
  - Range-checked load.
  - Instantiated four times for time.
- Alarm digits are plain range-checked registers.

Test Plan:
- Reset → all digits 0, alarm_ring=0; 3 ticks with dicRun=0 → time stays 00:00.
- dicRun=1, load 5,9,5,8 via dicLdMtens..Sones (one per cycle), then 2 ticks → 59:58, 59:59, then 00:00 on the second tick.
- Load Mtens with ld_digit=7 → Mtens unchanged; load Sones with 9 → Sones=9; tick and dicLdStens together → tick ignored, only Stens loads.
- Alarm set to 00:05 with alarm_en=1, time 00:03 running → alarm_ring=0 after the tick to 00:04, 1 after the tick to 00:05, still 1 at 00:07; alarm_en→0 → ring clears next edge.
- Time loaded to equal alarm 12:34 with alarm_en=1, no tick → alarm_ring stays 0; with alarm_en=0 and an increment match → stays 0.
- rst low while alarm_ring=1 and a load strobe is active → next edge all digits 0 and ring 0; rst high → counting resumes from 00:00.
